// File: rtl/pipe_stage_chain_pkg.sv
// Shared constants and helpers for the parametrised pipeline register chain.
// Occupancy counters are sized here so every user agrees on the width.
package pipe_stage_chain_pkg;

  localparam int unsigned MAX_DEPTH   = 64;
  localparam int unsigned STAGE_IDX_W = $clog2(MAX_DEPTH);

  // Bits needed to count 0..depth valid stages inclusive.
  function automatic int unsigned occ_width(input int unsigned depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_stage_chain_reg.sv
// One pipeline slot: a valid bit plus payload with load and clear enables.
// Data only changes on a valid load, so bubbles leave the payload untouched.
module pipe_stage_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  input  logic             clear,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic             valid_reg;
  logic [WIDTH-1:0] data_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else if (clear) begin
      valid_reg <= 1'b0;
    end else if (load) begin
      valid_reg <= load_valid;
      if (load_valid) begin
        data_reg <= load_data;
      end
    end
  end

  assign valid = valid_reg;
  assign data  = data_reg;

endmodule

// File: rtl/pipe_stage_chain.sv
// DEPTH-deep valid/ready register chain with stall, flush and occupancy count.
// COLLAPSE selects bubble-squeezing advance versus whole-chain lockstep hold.
module pipe_stage_chain
  import pipe_stage_chain_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 3,
  parameter int COLLAPSE = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  input  logic                         stall,
  input  logic                         flush,
  output logic [DEPTH-1:0]             stage_valid,
  output logic [DEPTH*WIDTH-1:0]       stage_data,
  output logic [occ_width(DEPTH)-1:0]  occupancy
);

  localparam int OCC_W = occ_width(DEPTH);
  localparam logic [OCC_W-1:0] OCC_ONE = OCC_W'(1);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] ld;
  logic [DEPTH-1:0] clr;
  logic [DEPTH-1:0] src_v;
  logic [WIDTH-1:0] src_d [DEPTH];
  logic [WIDTH-1:0] q     [DEPTH];

  logic             a_last;
  logic             flush_eff;
  logic             accept;
  logic             xfer;
  logic [OCC_W-1:0] occ_reg;
  logic [OCC_W-1:0] occ_next;

  // A flush coinciding with a stall is dropped; the caller must hold it.
  assign flush_eff = flush & ~stall;
  assign a_last    = out_ready & ~stall;
  assign out_valid = v[DEPTH-1] & ~flush_eff;
  assign out_data  = q[DEPTH-1];

  // Collapsing: a stage may advance if any later stage is empty or the output drains.
  always_comb begin
    logic hole;
    hole = 1'b0;
    adv  = '0;
    adv[DEPTH-1] = a_last;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      hole   = hole | ~v[i+1];
      adv[i] = (COLLAPSE != 0) ? (a_last | hole) : (a_last | ~out_valid);
    end
  end

  generate
    if (COLLAPSE != 0) begin : g_ready_collapse
      assign in_ready = (~v[0] | adv[0]) & ~stall & ~flush;
    end else begin : g_ready_lockstep
      assign in_ready = adv[0] & ~stall & ~flush;
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign ld[gi]    = in_ready;
        assign src_v[gi] = in_valid;
        assign src_d[gi] = in_data;
      end else begin : g_body
        assign ld[gi]    = adv[gi-1] & ~stall & ~flush;
        assign src_v[gi] = v[gi-1];
        assign src_d[gi] = q[gi-1];
      end

      // Emptied without a reload (or flushed): drop the valid bit.
      assign clr[gi] = flush_eff | (adv[gi] & ~stall & ~ld[gi]);

      pipe_stage_reg #(
        .WIDTH(WIDTH)
      ) u_reg (
        .clk        (clk),
        .rst        (rst),
        .load       (ld[gi]),
        .load_valid (src_v[gi]),
        .load_data  (src_d[gi]),
        .clear      (clr[gi]),
        .valid      (v[gi]),
        .data       (q[gi])
      );

      assign stage_data[gi*WIDTH +: WIDTH] = q[gi];
    end
  endgenerate

  assign stage_valid = v;

  assign accept = in_valid & in_ready;
  assign xfer   = out_valid & out_ready & ~stall;

  always_comb begin
    occ_next = occ_reg;
    if (flush_eff) begin
      occ_next = '0;
    end else if (accept && !xfer) begin
      occ_next = occ_reg + OCC_ONE;
    end else if (!accept && xfer) begin
      occ_next = occ_reg - OCC_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_reg <= '0;
    end else begin
      occ_reg <= occ_next;
    end
  end

  assign occupancy = occ_reg;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Scoreboard bench: a collapsing and a lockstep chain share one stimulus stream,
// each tracked by an entry/position model and an in-order expected-output queue.
module tb_pipe_stage_chain;

  localparam int W = 32;
  localparam int D = 3;

  typedef struct {
    logic [W-1:0] data;
    int           pos;
  } ent_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         stall = 1'b0;
  logic         flush = 1'b0;
  logic [W-1:0] in_data = '0;

  logic         in_ready_w  [2];
  logic         out_valid_w [2];
  logic [W-1:0] out_data_w  [2];
  logic [D-1:0] sv_w        [2];
  logic [D*W-1:0] sd_w      [2];
  logic [1:0]   occ_w       [2];

  ent_t         cq[$];
  ent_t         lq[$];
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit trk      = 1'b0;
  int first_acc = -1;
  int first_ov  = -1;
  int last_ov   = -1;
  int ov_cnt    = 0;

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      pipe_stage_chain #(
        .WIDTH    (W),
        .DEPTH    (D),
        .COLLAPSE ((gi == 0) ? 1 : 0)
      ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready_w[gi]),
        .in_data     (in_data),
        .out_valid   (out_valid_w[gi]),
        .out_ready   (out_ready),
        .out_data    (out_data_w[gi]),
        .stall       (stall),
        .flush       (flush),
        .stage_valid (sv_w[gi]),
        .stage_data  (sd_w[gi]),
        .occupancy   (occ_w[gi])
      );
    end
  endgenerate

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Compare one DUT against its model; returns whether the model says it accepts now.
  task automatic check_model(input int m, output bit acc);
    ent_t         q[$];
    logic [D-1:0] esv;
    bit           ho;
    bit           rdy;
    if (m == 0) q = cq; else q = lq;
    esv = '0;
    foreach (q[k]) begin
      esv[q[k].pos] = 1'b1;
      chk($sformatf("m%0d_stage%0d_data", m, q[k].pos), sd_w[m][q[k].pos*W +: W], q[k].data);
    end
    ho = (q.size() > 0) && (q[0].pos == D - 1);
    if (stall || flush) rdy = 1'b0;
    else if (m == 0)    rdy = (q.size() < D) || out_ready;
    else                rdy = out_ready || !ho;
    chk($sformatf("m%0d_in_ready", m), in_ready_w[m], rdy);
    chk($sformatf("m%0d_out_valid", m), out_valid_w[m], ho && !(flush && !stall));
    chk($sformatf("m%0d_stage_valid", m), sv_w[m], esv);
    chk($sformatf("m%0d_occupancy", m), occ_w[m], q.size());
    acc = in_valid && rdy;
  endtask

  task automatic step_collapse(input bit acc);
    int   lim;
    int   np;
    ent_t e;
    if (stall) return;
    if (flush) begin
      cq.delete();
      exp_q0.delete();
      return;
    end
    if (cq.size() > 0 && cq[0].pos == D - 1 && out_ready) void'(cq.pop_front());
    lim = D - 1;
    for (int k = 0; k < cq.size(); k++) begin
      e  = cq[k];
      np = (e.pos + 1 > lim) ? lim : e.pos + 1;
      e.pos = np;
      cq[k] = e;
      lim = np - 1;
    end
    if (acc) cq.push_back('{in_data, 0});
  endtask

  task automatic step_lockstep(input bit acc);
    ent_t e;
    bit   ho;
    if (stall) return;
    if (flush) begin
      lq.delete();
      exp_q1.delete();
      return;
    end
    ho = (lq.size() > 0) && (lq[0].pos == D - 1);
    if (out_ready || !ho) begin
      if (ho) void'(lq.pop_front());
      for (int k = 0; k < lq.size(); k++) begin
        e = lq[k];
        e.pos = e.pos + 1;
        lq[k] = e;
      end
    end
    if (acc) lq.push_back('{in_data, 0});
  endtask

  task automatic cycle();
    bit a0;
    bit a1;
    @(negedge clk);
    check_model(0, a0);
    check_model(1, a1);
    if (a0) exp_q0.push_back(in_data);
    if (a1) exp_q1.push_back(in_data);
    if (trk) begin
      if (first_acc < 0 && in_valid && in_ready_w[0]) first_acc = cyc;
      if (out_valid_w[0]) begin
        if (first_ov < 0) first_ov = cyc;
        last_ov = cyc;
        ov_cnt++;
      end
    end
    @(posedge clk);
    step_collapse(a0);
    step_lockstep(a1);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("m%0d_rst_stage_valid", m), sv_w[m], '0);
      chk($sformatf("m%0d_rst_out_valid", m), out_valid_w[m], 1'b0);
      chk($sformatf("m%0d_rst_occupancy", m), occ_w[m], '0);
    end
    cq.delete(); lq.delete(); exp_q0.delete(); exp_q1.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: pops the expected stream whenever a DUT completes an output transfer.
  always @(negedge clk) begin
    if (!rst && out_ready && !stall) begin
      for (int m = 0; m < 2; m++) begin
        if (out_valid_w[m]) begin
          if (m == 0 && exp_q0.size() == 0 || m == 1 && exp_q1.size() == 0) begin
            chk($sformatf("m%0d_unexpected_output", m), out_data_w[m], 128'hdead);
          end else if (m == 0) begin
            chk("m0_out_data", out_data_w[0], exp_q0.pop_front());
          end else begin
            chk("m1_out_data", out_data_w[1], exp_q1.pop_front());
          end
        end
      end
    end
  end

  initial begin
    do_reset();
    chk("m0_rst_stage_data", sd_w[0], '0);

    // Streaming at full rate
    trk = 1'b1;
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = W'(i);
      cycle();
      if (i == 6) chk("stream_occupancy", occ_w[0], 3);
    end
    in_valid = 1'b0;
    repeat (5) cycle();
    trk = 1'b0;
    chk("stream_latency", first_ov - first_acc, 3);
    chk("stream_count", ov_cnt, 8);
    chk("stream_no_gaps", last_ov - first_ov, 7);

    // Backpressure with a bubble
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hA; cycle();
    in_valid = 1'b0;                  cycle();
    in_valid = 1'b1; in_data = 32'hB; cycle();
    in_data = 32'hC;                  cycle();
    in_data = 32'hD;                  cycle();
    chk("bp_c_stage_valid", sv_w[0], 3'b111);
    chk("bp_c_stage2", sd_w[0][2*W +: W], 32'hA);
    chk("bp_c_stage1", sd_w[0][W +: W], 32'hB);
    chk("bp_c_stage0", sd_w[0][0 +: W], 32'hC);
    chk("bp_c_in_ready", in_ready_w[0], 1'b0);
    chk("bp_c_occupancy", occ_w[0], 3);
    chk("bp_l_stage_valid", sv_w[1], 3'b101);
    chk("bp_l_stage2", sd_w[1][2*W +: W], 32'hA);
    chk("bp_l_stage0", sd_w[1][0 +: W], 32'hB);
    chk("bp_l_in_ready", in_ready_w[1], 1'b0);
    chk("bp_l_occupancy", occ_w[1], 2);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k == 1) in_valid = 1'b0;
      chk("bp_c_drain_consecutive", out_valid_w[0], 1'b1);
      cycle();
    end
    repeat (4) cycle();

    // Flush mid-stream
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 32'h100 + W'(i); cycle();
    end
    flush = 1'b1; in_data = 32'h55;
    #1;
    chk("flush_in_ready", in_ready_w[0], 1'b0);
    chk("flush_out_valid", out_valid_w[0], 1'b0);
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("flush_c_stage_valid", sv_w[0], 3'b000);
    chk("flush_c_occupancy", occ_w[0], 0);
    chk("flush_l_stage_valid", sv_w[1], 3'b000);
    repeat (4) cycle();

    // Stall beats flush
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 32'h200 + W'(i); cycle();
    end
    stall = 1'b1; flush = 1'b1; out_ready = 1'b1; in_data = 32'h77;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) flush = 1'b0;
      #1;
      chk("stall_in_ready", in_ready_w[0], 1'b0);
      chk("stall_out_valid_visible", out_valid_w[0], 1'b1);
      cycle();
    end
    chk("stall_occupancy", occ_w[0], 3);
    chk("stall_stage_valid", sv_w[0], 3'b111);
    chk("stall_stage0", sd_w[0][0 +: W], 32'h202);
    stall = 1'b0; in_valid = 1'b0;
    repeat (5) cycle();

    // Asynchronous reset between edges
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 32'h300 + W'(i); cycle();
    end
    in_valid = 1'b0;
    chk("pre_areset_occupancy", occ_w[0], 2);
    #2;
    rst = 1'b1;
    #1;
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("m%0d_areset_stage_valid", m), sv_w[m], '0);
      chk($sformatf("m%0d_areset_out_valid", m), out_valid_w[m], 1'b0);
      chk($sformatf("m%0d_areset_occupancy", m), occ_w[m], '0);
    end
    cq.delete(); lq.delete(); exp_q0.delete(); exp_q1.delete();
    @(negedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b1; in_data = 32'h400; out_ready = 1'b1;
    #1;
    chk("post_reset_accept_c", in_ready_w[0], 1'b1);
    chk("post_reset_accept_l", in_ready_w[1], 1'b1);
    cycle();
    in_valid = 1'b0;
    repeat (4) cycle();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 9) < 6);
      stall     = ($urandom_range(0, 9) == 0);
      flush     = ($urandom_range(0, 19) == 0);
      cycle();
    end
    stall = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (8) cycle();
    chk("drain_q0_empty", exp_q0.size(), 0);
    chk("drain_q1_empty", exp_q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
